gpc15_3_checker: RTL

- Synthesizable self-checking scoreboard at the output end of the gpc15_3 compressor.
- Consumes a valid/ready stream of (src0, src1, dst) samples captured around a gpc15_3 instance.
- Recomputes the weighted sum (five weight-1 bits plus one weight-2 bit) and compares it against dst.
- Accumulates pass/fail statistics and captures the first mismatch; used for on-FPGA BIST of generated GPC cells.

---
 rtl/gpc15_3_chk_pkg.sv | 21 ++
 rtl/gpc15_3_ref.sv | 30 +++
 rtl/gpc15_3_checker.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/gpc15_3_chk_pkg.sv
// Shared definitions for the gpc15_3 output checker.
// Holds the run-control state encoding, the GPC operand/result widths and
// the column weights of the two input groups, so the reference model and
// the scoreboard agree on one source of truth.
package gpc15_3_chk_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int SRC0_W = 5;
   localparam int SRC1_W = 1;
   localparam int DST_W  = 3;

   localparam int W0 = 1;
   localparam int W1 = 2;

endpackage

// File: rtl/gpc15_3_ref.sv
// Combinational golden model of a (1,5;3) generalised parallel counter.
// Ports:
//    src0 - weight-1 input bits
//    src1 - weight-2 input bit(s)
//    sum  - weighted bit count, 0..7 for the 5+1 configuration
module gpc15_3_ref
   import gpc15_3_chk_pkg::*;
(
   input  logic [SRC0_W-1:0] src0,
   input  logic [SRC1_W-1:0] src1,
   output logic [DST_W-1:0]  sum
);

   // Add the column weight once for every set bit; the largest possible
   // total is 5*1 + 1*2 = 7, which fits the result width exactly.
   always_comb begin
      sum = '0;
      for (int i = 0; i < SRC0_W; i++) begin
         if (src0[i]) begin
            sum = sum + DST_W'(W0);
         end
      end
      for (int j = 0; j < SRC1_W; j++) begin
         if (src1[j]) begin
            sum = sum + DST_W'(W1);
         end
      end
   end

endmodule

// File: rtl/gpc15_3_checker.sv
// On-chip scoreboard for a gpc15_3 compressor instance.
// Accepts a valid/ready stream of (src0, src1, dst) samples, recomputes the
// weighted sum, and tallies matches and mismatches over a run of EXPECT_N
// samples, capturing details of the first mismatch.
// Ports:
//    clk, rst_n        - clock (rising edge), async active-low reset
//    start             - pulse, begins a run from IDLE or DONE
//    in_valid/in_ready - sample handshake
//    in_src0/in_src1   - GPC inputs of the sample
//    in_dst            - GPC output under test
//    busy, done, pass  - run status
//    pass_cnt/fail_cnt - saturating match / mismatch counts
//    first_fail_*      - index, expected and observed value of first mismatch
module gpc15_3_checker
   import gpc15_3_chk_pkg::*;
#(
   parameter int CNT_W    = 16,
   parameter int EXPECT_N = 20
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SRC0_W-1:0] in_src0,
   input  logic [SRC1_W-1:0] in_src1,
   input  logic [DST_W-1:0]  in_dst,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  pass_cnt,
   output logic [CNT_W-1:0]  fail_cnt,
   output logic [CNT_W-1:0]  first_fail_idx,
   output logic [DST_W-1:0]  first_fail_exp,
   output logic [DST_W-1:0]  first_fail_got
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(EXPECT_N - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   state_t            state;
   state_t            nextState;
   logic [CNT_W-1:0]  sampleIdx;
   logic              xfer;
   logic              startOk;
   logic [DST_W-1:0]  expSum;
   logic              stageValid;
   logic [DST_W-1:0]  stageExp;
   logic [DST_W-1:0]  stageGot;
   logic [CNT_W-1:0]  stageIdx;
   logic              firstSeen;

   gpc15_3_ref refModel (
      .src0 (in_src0),
      .src1 (in_src1),
      .sum  (expSum)
   );

   // Every output status flag decodes straight from the state register, so
   // in_ready rises the cycle after start and falls the cycle after the
   // last transfer. pass is only meaningful once the run has retired.
   always_comb begin
      xfer     = in_valid && in_ready;
      startOk  = start && ((state == IDLE) || (state == DONE));
      in_ready = (state == RUN);
      busy     = (state == RUN) || (state == DRAIN);
      done     = (state == DONE);
      pass     = (state == DONE) && (fail_cnt == '0);
   end

   // Next-state logic. A stray start while a run is in flight has no
   // effect; an unrecognised encoding falls back to IDLE.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (start) begin
               nextState = RUN;
            end
         end
         RUN: begin
            if (xfer && (sampleIdx == LAST_IDX)) begin
               nextState = DRAIN;
            end
         end
         DRAIN: begin
            nextState = DONE;
         end
         DONE: begin
            if (start) begin
               nextState = RUN;
            end
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Index of the next sample to be accepted; restarts at zero per run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sampleIdx <= '0;
      end else if (startOk) begin
         sampleIdx <= '0;
      end else if (xfer) begin
         sampleIdx <= sampleIdx + 1'b1;
      end
   end

   // Stage 1: latch the accepted sample together with its expected sum so
   // the compare and counter update happen one cycle later off registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stageValid <= 1'b0;
         stageExp   <= '0;
         stageGot   <= '0;
         stageIdx   <= '0;
      end else begin
         stageValid <= xfer;
         if (xfer) begin
            stageExp <= expSum;
            stageGot <= in_dst;
            stageIdx <= sampleIdx;
         end
      end
   end

   // Stage 2: tally the staged sample. Counters stick at all-ones rather
   // than wrapping, and the first mismatch of a run is frozen by firstSeen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         firstSeen      <= 1'b0;
         first_fail_idx <= '0;
         first_fail_exp <= '0;
         first_fail_got <= '0;
      end else if (startOk) begin
         pass_cnt       <= '0;
         fail_cnt       <= '0;
         firstSeen      <= 1'b0;
         first_fail_idx <= '0;
         first_fail_exp <= '0;
         first_fail_got <= '0;
      end else if (stageValid) begin
         if (stageExp == stageGot) begin
            if (pass_cnt != CNT_MAX) begin
               pass_cnt <= pass_cnt + 1'b1;
            end
         end else begin
            if (fail_cnt != CNT_MAX) begin
               fail_cnt <= fail_cnt + 1'b1;
            end
            if (!firstSeen) begin
               firstSeen      <= 1'b1;
               first_fail_idx <= stageIdx;
               first_fail_exp <= stageExp;
               first_fail_got <= stageGot;
            end
         end
      end
   end

endmodule
